// File: rtl/player_pkg.sv
// rtl/player_pkg.sv - shared types and constants for the player block
package player_pkg;

    typedef enum logic [1:0] {
        ST_HOLD = 2'd0,
        ST_RISE = 2'd1,
        ST_FALL = 2'd2,
        ST_DEAD = 2'd3
    } state_t;

    localparam int SCREEN_H = 768;
    localparam int X_W      = 11;
    localparam int Y_W      = 10;
    localparam int V_W      = 9;
    localparam int CALC_W   = 12;
    localparam int RGB_W    = 12;

    localparam logic [1:0] GS_MENU = 2'd0;
    localparam logic [1:0] GS_RUN  = 2'd1;

    typedef logic signed [V_W-1:0]    vel_t;
    typedef logic signed [CALC_W-1:0] calc_t;

    // Screen y cannot go above the top edge.
    function automatic logic [Y_W-1:0] clamp_y(input calc_t v);
        return (v < 0) ? '0 : v[Y_W-1:0];
    endfunction

endpackage

// File: rtl/player_kinematics_if.sv
// rtl/player_kinematics_if.sv - beam, sprite ROM and pixel output bundle
interface player_kinematics_if #(
    parameter int ADDR_W = 14
);
    import player_pkg::*;

    logic [X_W-1:0]    beam_x;
    logic [Y_W-1:0]    beam_y;
    logic [ADDR_W-1:0] rom_addr;
    logic [RGB_W-1:0]  rom_rgb;
    logic              rom_alpha;
    logic [RGB_W-1:0]  color;
    logic              is_transparent;

    modport master (
        output beam_x, beam_y, rom_rgb, rom_alpha,
        input  rom_addr, color, is_transparent
    );

    modport slave (
        input  beam_x, beam_y, rom_rgb, rom_alpha,
        output rom_addr, color, is_transparent
    );

endinterface

// File: rtl/player_sprite_fetch.sv
// rtl/player_sprite_fetch.sv - three-stage sprite hit test and ROM fetch
module player_sprite_fetch
    import player_pkg::*;
#(
    parameter int SPRITE_W = 80,
    parameter int SPRITE_H = 80,
    parameter int ADDR_W   = 14
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [X_W-1:0]    i_x,
    input  logic [Y_W-1:0]    i_y,
    input  logic              i_facing,
    input  logic [X_W-1:0]    i_beam_x,
    input  logic [Y_W-1:0]    i_beam_y,
    input  logic [RGB_W-1:0]  i_rom_rgb,
    input  logic              i_rom_alpha,
    output logic [ADDR_W-1:0] o_rom_addr,
    output logic [RGB_W-1:0]  o_color,
    output logic              o_is_transparent
);

    localparam logic [CALC_W-1:0] L_SW     = CALC_W'(SPRITE_W);
    localparam logic [CALC_W-1:0] L_SH     = CALC_W'(SPRITE_H);
    localparam logic [ADDR_W-1:0] L_ROW    = ADDR_W'(SPRITE_W);
    localparam logic [ADDR_W-1:0] L_FRAME  = ADDR_W'(SPRITE_W * SPRITE_H);

    logic [CALC_W-1:0] w_bx, w_by, w_px, w_py, w_dx, w_dy;
    logic              w_hit;
    logic [ADDR_W-1:0] w_addr;

    logic              r_hit_d1;
    logic              r_hit_d2;
    logic [ADDR_W-1:0] r_rom_addr;
    logic [RGB_W-1:0]  r_color;
    logic              r_transparent;

    // Widen to a common unsigned width so x+W and y+H cannot wrap.
    assign w_bx  = {1'b0, i_beam_x};
    assign w_px  = {1'b0, i_x};
    assign w_by  = {2'b00, i_beam_y};
    assign w_py  = {2'b00, i_y};
    assign w_dx  = w_bx - w_px;
    assign w_dy  = w_by - w_py;
    assign w_hit = (w_bx >= w_px) && (w_bx < w_px + L_SW) &&
                   (w_by >= w_py) && (w_by < w_py + L_SH);

    // Left-facing frame is stored directly after the right-facing one.
    assign w_addr = (i_facing ? L_FRAME : '0) + ADDR_W'(w_dy) * L_ROW + ADDR_W'(w_dx);

    // Stage 1: register the hit and launch the ROM address; misses keep the old address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_d1   <= 1'b0;
            r_rom_addr <= '0;
        end else begin
            r_hit_d1 <= w_hit;
            if (w_hit) begin
                r_rom_addr <= w_addr;
            end
        end
    end

    // Stage 2: hit travels alongside the ROM read latency.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_d2 <= 1'b0;
        end else begin
            r_hit_d2 <= r_hit_d1;
        end
    end

    // Stage 3: capture ROM data for owned pixels; colour holds across misses.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_color       <= '0;
            r_transparent <= 1'b1;
        end else if (r_hit_d2) begin
            r_color       <= i_rom_rgb;
            r_transparent <= i_rom_alpha;
        end else begin
            r_transparent <= 1'b1;
        end
    end

    assign o_rom_addr       = r_rom_addr;
    assign o_color          = r_color;
    assign o_is_transparent = r_transparent;

endmodule

// File: rtl/player_kinematics.sv
// rtl/player_kinematics.sv - player physics state machine and sprite pixel source
module player_kinematics
    import player_pkg::*;
#(
    parameter int SPRITE_W    = 80,
    parameter int SPRITE_H    = 80,
    parameter int FIELD_LEFT  = 300,
    parameter int FIELD_RIGHT = 642,
    parameter int START_X     = 472,
    parameter int START_Y     = 687,
    parameter int JUMP_V      = 40,
    parameter int BOOST_V     = 64,
    parameter int GRAVITY     = 4,
    parameter int VMAX        = 48
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_frame_tick,
    input  logic [1:0]            i_game_state,
    input  logic signed [V_W-1:0] i_delta_x,
    input  logic                  i_land,
    input  logic                  i_boost,
    input  logic [Y_W-1:0]        i_ground_y,
    player_kinematics_if.slave    pix,
    output logic [X_W-1:0]        o_doodle_x,
    output logic [Y_W-1:0]        o_doodle_y,
    output logic signed [V_W-1:0] o_vel_y,
    output logic                  o_falling,
    output logic                  o_facing_left,
    output logic                  o_dead
);

    localparam int ADDR_W = $clog2(2 * SPRITE_W * SPRITE_H);

    localparam vel_t             L_JUMP     = vel_t'(-JUMP_V);
    localparam vel_t             L_BOOST    = vel_t'(-BOOST_V);
    localparam vel_t             L_GRAV     = vel_t'(GRAVITY);
    localparam vel_t             L_VMAX     = vel_t'(VMAX);
    localparam calc_t            L_SPR_H    = calc_t'(SPRITE_H);
    localparam calc_t            L_SCREEN   = calc_t'(SCREEN_H);
    localparam calc_t            L_LEFT     = calc_t'(FIELD_LEFT);
    localparam calc_t            L_RIGHT    = calc_t'(FIELD_RIGHT);
    localparam logic [X_W-1:0]   L_WRAP_L   = X_W'(FIELD_RIGHT - 1);
    localparam logic [X_W-1:0]   L_WRAP_R   = X_W'(FIELD_LEFT + 1);
    localparam logic [X_W-1:0]   L_START_X  = X_W'(START_X);
    localparam logic [Y_W-1:0]   L_START_Y  = Y_W'(START_Y);
    localparam logic [Y_W-1:0]   L_LAND_OFS = Y_W'(SPRITE_H + 1);

    state_t         r_state;
    logic [X_W-1:0] r_x;
    logic [Y_W-1:0] r_y;
    vel_t           r_vel;
    logic           r_facing;
    logic           r_falling;
    logic           r_dead;

    logic           w_run;
    calc_t          w_y_ext, w_vel_ext, w_y_sum;
    calc_t          w_x_ext, w_dx_ext, w_x_sum;
    logic           w_die;
    vel_t           w_vel_inc, w_vel_next;
    logic [X_W-1:0] w_x_next;
    logic [Y_W-1:0] w_land_y;
    logic           w_facing_next;
    logic           w_contact;

    assign w_run     = (i_game_state == GS_RUN);
    assign w_contact = i_land | i_boost;

    // Vertical step in 12-bit signed so an upward move past the top edge is detectable.
    assign w_y_ext   = calc_t'({2'b00, r_y});
    assign w_vel_ext = {{(CALC_W-V_W){r_vel[V_W-1]}}, r_vel};
    assign w_y_sum   = w_y_ext + w_vel_ext;
    assign w_die     = (w_y_sum + L_SPR_H) >= L_SCREEN;

    assign w_vel_inc  = r_vel + L_GRAV;
    assign w_vel_next = (w_vel_inc > L_VMAX) ? L_VMAX : w_vel_inc;

    assign w_land_y   = i_ground_y - L_LAND_OFS;

    // Horizontal wrap: crossing either threshold re-enters just inside the opposite side.
    assign w_x_ext  = calc_t'({1'b0, r_x});
    assign w_dx_ext = {{(CALC_W-V_W){i_delta_x[V_W-1]}}, i_delta_x};
    assign w_x_sum  = w_x_ext + w_dx_ext;
    assign w_x_next = (w_x_sum <= L_LEFT)  ? L_WRAP_L :
                      (w_x_sum >= L_RIGHT) ? L_WRAP_R :
                      w_x_sum[X_W-1:0];

    assign w_facing_next = (i_delta_x < 0) ? 1'b1 :
                           (i_delta_x > 0) ? 1'b0 : r_facing;

    // Movement state machine: all physics happens on frame ticks only.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_HOLD;
            r_x       <= L_START_X;
            r_y       <= L_START_Y;
            r_vel     <= '0;
            r_facing  <= 1'b0;
            r_falling <= 1'b0;
            r_dead    <= 1'b0;
        end else begin
            r_dead <= 1'b0;
            if (i_frame_tick) begin
                if (w_run && r_state != ST_DEAD) begin
                    r_facing <= w_facing_next;
                end
                case (r_state)
                    ST_HOLD: begin
                        if (w_run) begin
                            r_state   <= ST_RISE;
                            r_vel     <= L_JUMP;
                            r_falling <= 1'b0;
                        end
                    end
                    ST_RISE, ST_FALL: begin
                        if (w_run) begin
                            if (r_state == ST_FALL && w_contact) begin
                                // Landing beats death; spring wins over plain platform.
                                r_state   <= ST_RISE;
                                r_falling <= 1'b0;
                                r_y       <= w_land_y;
                                r_vel     <= i_boost ? L_BOOST : L_JUMP;
                                r_x       <= w_x_next;
                            end else if (r_state == ST_FALL && w_die) begin
                                r_state   <= ST_DEAD;
                                r_falling <= 1'b0;
                                r_dead    <= 1'b1;
                            end else begin
                                r_y   <= clamp_y(w_y_sum);
                                r_vel <= w_vel_next;
                                r_x   <= w_x_next;
                                if (r_state == ST_RISE && w_vel_next > 0) begin
                                    r_state   <= ST_FALL;
                                    r_falling <= 1'b1;
                                end
                            end
                        end
                    end
                    ST_DEAD: begin
                        if (i_game_state == GS_MENU) begin
                            r_state   <= ST_HOLD;
                            r_x       <= L_START_X;
                            r_y       <= L_START_Y;
                            r_vel     <= '0;
                            r_falling <= 1'b0;
                        end
                    end
                    default: begin
                        r_state <= ST_HOLD;
                    end
                endcase
            end
        end
    end

    player_sprite_fetch #(
        .SPRITE_W (SPRITE_W),
        .SPRITE_H (SPRITE_H),
        .ADDR_W   (ADDR_W)
    ) u_fetch (
        .clk              (clk),
        .rst              (rst),
        .i_x              (r_x),
        .i_y              (r_y),
        .i_facing         (r_facing),
        .i_beam_x         (pix.beam_x),
        .i_beam_y         (pix.beam_y),
        .i_rom_rgb        (pix.rom_rgb),
        .i_rom_alpha      (pix.rom_alpha),
        .o_rom_addr       (pix.rom_addr),
        .o_color          (pix.color),
        .o_is_transparent (pix.is_transparent)
    );

    assign o_doodle_x    = r_x;
    assign o_doodle_y    = r_y;
    assign o_vel_y       = r_vel;
    assign o_falling     = r_falling;
    assign o_facing_left = r_facing;
    assign o_dead        = r_dead;

endmodule
